// File: rtl/stage_memory_access.sv
// Memory-access pipeline stage: issues loads/stores over a req/gnt/rvalid bus,
// flags misaligned accesses and response timeouts, and registers the M/W outputs.
module stage_memory_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x_valid,
    input  logic [31:0] x_pc,
    input  logic [31:0] x_inst,
    input  logic [31:0] x_alu_result,
    input  logic [31:0] x_store_data,
    input  logic [4:0]  x_rd_addr,
    input  logic        x_reg_we,
    input  logic        x_load,
    input  logic        x_store,
    input  logic [2:0]  x_funct3,
    output logic        m_stall,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] w_pc,
    output logic [31:0] w_inst,
    output logic [31:0] w_alu_result,
    output logic [31:0] w_mem_data,
    output logic [4:0]  w_rd_addr,
    output logic        w_reg_we,
    output logic        w_load,
    output logic [2:0]  w_funct3,
    output logic [1:0]  w_byte_offset,
    output logic        m_misaligned,
    output logic        m_bus_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic [4:0]  rd_addr;
        logic        reg_we;
        logic        load;
        logic [2:0]  funct3;
        logic [1:0]  byte_offset;
        logic        misaligned;
        logic        bus_err;
    } wb_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu_result;
        logic [4:0]  rd_addr;
        logic        reg_we;
        logic        load;
        logic        store;
        logic [2:0]  funct3;
        logic [3:0]  be;
        logic [31:0] wdata;
    } hold_t;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    hold_t         hold_q, hold_d;
    wb_t           w_q, w_d;

    logic [3:0]  x_be;
    logic [31:0] x_wdata;
    logic        x_misaligned, accept;
    wb_t         x_wb, hold_wb;

    // Store lane steering: the byte/half is replicated across the word so the
    // memory only has to honour the byte enables.
    always_comb begin
        x_be    = '0;
        x_wdata = '0;
        if (x_store) begin
            case (x_funct3[1:0])
                2'b00: begin
                    x_be    = 4'b0001 << x_alu_result[1:0];
                    x_wdata = {4{x_store_data[7:0]}};
                end
                2'b01: begin
                    x_be    = 4'b0011 << x_alu_result[1:0];
                    x_wdata = {2{x_store_data[15:0]}};
                end
                default: begin
                    x_be    = 4'b1111;
                    x_wdata = x_store_data;
                end
            endcase
        end
    end

    assign x_misaligned = ((x_funct3[1:0] == 2'b01) && x_alu_result[0]) ||
                          ((x_funct3[1:0] == 2'b10) && (x_alu_result[1:0] != 2'b00));
    assign accept = x_valid && (x_inst != '0) && (state_q == S_IDLE);

    always_comb begin
        x_wb             = '0;
        x_wb.pc          = x_pc;
        x_wb.inst        = x_inst;
        x_wb.alu_result  = x_alu_result;
        x_wb.rd_addr     = x_rd_addr;
        x_wb.reg_we      = x_reg_we;
        x_wb.load        = x_load;
        x_wb.funct3      = x_funct3;
        x_wb.byte_offset = x_alu_result[1:0];

        hold_wb             = '0;
        hold_wb.pc          = hold_q.pc;
        hold_wb.inst        = hold_q.inst;
        hold_wb.alu_result  = hold_q.alu_result;
        hold_wb.rd_addr     = hold_q.rd_addr;
        hold_wb.reg_we      = hold_q.reg_we;
        hold_wb.load        = hold_q.load;
        hold_wb.funct3      = hold_q.funct3;
        hold_wb.byte_offset = hold_q.alu_result[1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        w_d     = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (x_load || x_store) begin
                        if (x_misaligned) begin
                            w_d            = x_wb;
                            w_d.reg_we     = 1'b0;
                            w_d.misaligned = 1'b1;
                        end else begin
                            hold_d.pc         = x_pc;
                            hold_d.inst       = x_inst;
                            hold_d.alu_result = x_alu_result;
                            hold_d.rd_addr    = x_rd_addr;
                            hold_d.reg_we     = x_reg_we;
                            hold_d.load       = x_load;
                            hold_d.store      = x_store;
                            hold_d.funct3     = x_funct3;
                            hold_d.be         = x_be;
                            hold_d.wdata      = x_wdata;
                            state_d           = S_REQ;
                        end
                    end else begin
                        w_d = x_wb;
                    end
                end
            end
            S_REQ: begin
                if (dmem_gnt) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end
            end
            S_RESP: begin
                if (dmem_rvalid) begin
                    w_d          = hold_wb;
                    w_d.mem_data = hold_q.store ? 32'h0 : dmem_rdata;
                    state_d      = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    w_d         = hold_wb;
                    w_d.reg_we  = 1'b0;
                    w_d.bus_err = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            w_q     <= w_d;
        end
    end

    // Bus signals are zeroed outside REQ so nothing stale is visible to memory.
    assign m_stall    = (state_q != S_IDLE);
    assign dmem_req   = (state_q == S_REQ);
    assign dmem_addr  = dmem_req ? {hold_q.alu_result[31:2], 2'b00} : 32'h0;
    assign dmem_be    = dmem_req ? hold_q.be : 4'b0000;
    assign dmem_wdata = dmem_req ? hold_q.wdata : 32'h0;

    assign w_pc          = w_q.pc;
    assign w_inst        = w_q.inst;
    assign w_alu_result  = w_q.alu_result;
    assign w_mem_data    = w_q.mem_data;
    assign w_rd_addr     = w_q.rd_addr;
    assign w_reg_we      = w_q.reg_we;
    assign w_load        = w_q.load;
    assign w_funct3      = w_q.funct3;
    assign w_byte_offset = w_q.byte_offset;
    assign m_misaligned  = w_q.misaligned;
    assign m_bus_err     = w_q.bus_err;
endmodule

// File: tb/tb_stage_memory_access.sv
// Directed bench for stage_memory_access: expected W records are queued when an
// instruction is driven and compared when the stage emits a non-bubble W cycle.
module tb_stage_memory_access;
    logic        clk = 1'b0;
    logic        rst;
    logic        x_valid, x_reg_we, x_load, x_store;
    logic [31:0] x_pc, x_inst, x_alu_result, x_store_data;
    logic [4:0]  x_rd_addr;
    logic [2:0]  x_funct3;
    logic        m_stall, dmem_req, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] w_pc, w_inst, w_alu_result, w_mem_data;
    logic [4:0]  w_rd_addr;
    logic        w_reg_we, w_load, m_misaligned, m_bus_err;
    logic [2:0]  w_funct3;
    logic [1:0]  w_byte_offset;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic        mis;
        logic        berr;
    } wb_t;

    wb_t exp_q[$];
    bit  off_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    stage_memory_access #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_pc(x_pc), .x_inst(x_inst),
        .x_alu_result(x_alu_result), .x_store_data(x_store_data), .x_rd_addr(x_rd_addr),
        .x_reg_we(x_reg_we), .x_load(x_load), .x_store(x_store), .x_funct3(x_funct3),
        .m_stall(m_stall), .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .w_pc(w_pc), .w_inst(w_inst), .w_alu_result(w_alu_result),
        .w_mem_data(w_mem_data), .w_rd_addr(w_rd_addr), .w_reg_we(w_reg_we), .w_load(w_load),
        .w_funct3(w_funct3), .w_byte_offset(w_byte_offset), .m_misaligned(m_misaligned),
        .m_bus_err(m_bus_err)
    );

    always #5 clk = ~clk;

    function automatic wb_t w_act();
        return '{w_pc, w_inst, w_alu_result, w_mem_data, w_rd_addr, w_reg_we, w_load,
                 w_funct3, w_byte_offset, m_misaligned, m_bus_err};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop and compare on every non-bubble W cycle; bubbles must carry no flags.
    task automatic monitor();
        wb_t e;
        bit  chk_off;
        if (w_inst !== 32'h0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_w", w_inst, 32'h0);
            end else begin
                e       = exp_q.pop_front();
                chk_off = off_q.pop_front();
                if (!chk_off) e.off = w_byte_offset;
                chk("w_out", w_act(), e);
            end
        end else begin
            chk("bubble", {w_pc, w_mem_data, w_reg_we, w_load, m_misaligned, m_bus_err}, '0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic drive_x(input logic [31:0] pc, inst, alu, sd, input logic [4:0] rd,
                           input logic we, ld, st, input logic [2:0] f3);
        x_valid = 1'b1; x_pc = pc; x_inst = inst; x_alu_result = alu; x_store_data = sd;
        x_rd_addr = rd; x_reg_we = we; x_load = ld; x_store = st; x_funct3 = f3;
    endtask

    task automatic push(input wb_t e, input bit chk_off);
        exp_q.push_back(e);
        off_q.push_back(chk_off);
    endtask

    initial begin
        rst = 1'b0;
        x_valid = 0; x_pc = 0; x_inst = 0; x_alu_result = 0; x_store_data = 0;
        x_rd_addr = 0; x_reg_we = 0; x_load = 0; x_store = 0; x_funct3 = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        #12;
        chk("rst_w", w_act(), '0);
        chk("rst_bus", {m_stall, dmem_req, dmem_addr, dmem_be, dmem_wdata}, '0);
        #5 rst = 1'b1;
        tick();

        // ADD: one-cycle pass-through
        drive_x(32'h10, 32'h002081B3, 32'h55, 32'h0, 5'd3, 1, 0, 0, 3'b000);
        push('{32'h10, 32'h002081B3, 32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0}, 0);
        chk("add_stall_pre", m_stall, 1'b0);
        tick();
        x_valid = 0;
        chk("add_w_reg_we", {w_reg_we, m_stall}, 2'b10);

        // LW 0x104, immediate gnt, rvalid next cycle
        drive_x(32'h20, 32'h1042A283, 32'h104, 32'h0, 5'd5, 1, 1, 0, 3'b010);
        push('{32'h20, 32'h1042A283, 32'h104, 32'hDEADBEEF, 5'd5, 1'b1, 1'b1, 3'b010, 2'b00, 1'b0, 1'b0}, 1);
        tick();
        x_valid = 0;
        chk("lw_req", {dmem_req, dmem_addr, dmem_be, m_stall}, {1'b1, 32'h104, 4'b0000, 1'b1});
        dmem_gnt = 1;
        tick();
        dmem_gnt = 0;
        chk("lw_resp", {dmem_req, m_stall}, 2'b01);
        dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
        tick();
        dmem_rvalid = 0; dmem_rdata = 0;
        chk("lw_done_stall", m_stall, 1'b0);

        // SB 0x203, gnt held off three cycles
        drive_x(32'h24, 32'h00F281A3, 32'h203, 32'h12345678, 5'd0, 0, 0, 1, 3'b000);
        push('{32'h24, 32'h00F281A3, 32'h203, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000, 2'b11, 1'b0, 1'b0}, 1);
        tick();
        x_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("sb_req_hold", {dmem_req, dmem_addr, dmem_be, dmem_wdata},
                {1'b1, 32'h200, 4'b1000, 32'h78787878});
            dmem_gnt = (i == 3);
            tick();
        end
        dmem_gnt = 0;
        dmem_rvalid = 1; dmem_rdata = 32'hAAAA5555;
        tick();
        dmem_rvalid = 0; dmem_rdata = 0;

        // SH 0x102, ack after two response cycles
        drive_x(32'h28, 32'h00A29123, 32'h102, 32'hCAFEBABE, 5'd0, 0, 0, 1, 3'b001);
        push('{32'h28, 32'h00A29123, 32'h102, 32'h0, 5'd0, 1'b0, 1'b0, 3'b001, 2'b10, 1'b0, 1'b0}, 1);
        tick();
        x_valid = 0;
        chk("sh_req", {dmem_req, dmem_addr, dmem_be, dmem_wdata},
            {1'b1, 32'h100, 4'b1100, 32'hBABEBABE});
        dmem_gnt = 1;
        tick();
        dmem_gnt = 0;
        tick();
        chk("sh_wait_stall", {m_stall, dmem_req}, 2'b10);
        dmem_rvalid = 1;
        tick();
        dmem_rvalid = 0;

        // LH 0x101 and SW 0x106: misaligned, no bus access
        drive_x(32'h2C, 32'h00129303, 32'h101, 32'h0, 5'd6, 1, 1, 0, 3'b001);
        push('{32'h2C, 32'h00129303, 32'h101, 32'h0, 5'd6, 1'b0, 1'b1, 3'b001, 2'b01, 1'b1, 1'b0}, 1);
        chk("lh_no_req_pre", dmem_req, 1'b0);
        tick();
        chk("lh_no_req", {dmem_req, m_stall, m_misaligned}, 3'b001);
        drive_x(32'h30, 32'h0062A323, 32'h106, 32'h11, 5'd0, 0, 0, 1, 3'b010);
        push('{32'h30, 32'h0062A323, 32'h106, 32'h0, 5'd0, 1'b0, 1'b0, 3'b010, 2'b10, 1'b1, 1'b0}, 1);
        tick();
        x_valid = 0;
        chk("sw_mis_no_req", dmem_req, 1'b0);

        // Bubbles: valid with zero inst, and invalid with nonzero inst
        drive_x(32'h34, 32'h0, 32'h7, 32'h0, 5'd1, 1, 0, 0, 3'b000);
        tick();
        drive_x(32'h38, 32'h00100093, 32'h7, 32'h0, 5'd1, 1, 0, 0, 3'b000);
        x_valid = 0;
        tick();

        // LW 0x300 timeout; rvalid in the gnt cycle and after abort are ignored
        drive_x(32'h40, 32'h3002A383, 32'h300, 32'h0, 5'd7, 1, 1, 0, 3'b010);
        push('{32'h40, 32'h3002A383, 32'h300, 32'h0, 5'd7, 1'b0, 1'b1, 3'b010, 2'b00, 1'b0, 1'b1}, 1);
        tick();
        x_valid = 0;
        dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'h0BADF00D;
        tick();
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("to_wait", {m_bus_err, m_stall}, 2'b01);
        end
        tick();
        chk("to_pulse", {m_bus_err, w_reg_we, m_stall}, 3'b100);
        dmem_rvalid = 1; dmem_rdata = 32'h12121212;
        tick();
        dmem_rvalid = 0; dmem_rdata = 0;
        chk("to_late_rvalid", {m_bus_err, m_stall}, 2'b00);

        // Reset while in RESP: everything drops at once, held load is lost
        drive_x(32'h50, 32'h4002A403, 32'h400, 32'h0, 5'd8, 1, 1, 0, 3'b010);
        tick();
        x_valid = 0;
        dmem_gnt = 1;
        tick();
        dmem_gnt = 0;
        tick();
        chk("pre_rst_resp", m_stall, 1'b1);
        rst = 1'b0;
        #1;
        chk("rst_mid_bus", {dmem_req, m_stall}, 2'b00);
        chk("rst_mid_w", w_act(), '0);
        #2 rst = 1'b1;
        dmem_rvalid = 1; dmem_rdata = 32'h55555555;
        tick();
        dmem_rvalid = 0; dmem_rdata = 0;
        tick();
        drive_x(32'h60, 32'h00528533, 32'h99, 32'h0, 5'd10, 1, 0, 0, 3'b000);
        push('{32'h60, 32'h00528533, 32'h99, 32'h0, 5'd10, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0}, 0);
        tick();
        x_valid = 0;
        chk("post_rst_add", {w_inst, m_stall}, {32'h00528533, 1'b0});
        tick();

        chk("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
